// File: rtl/tile_map_ctrl.sv
// Tile map store for a tank-style game: reloads from a layout ROM, serves render reads,
// and resolves bullet impacts. Define TILE_MAP_WALL_HP_EN for two-hit walls (2->5->0).
module tile_map_ctrl #(
    parameter int MAP_W = 20,
    parameter int MAP_H = 15,
    parameter int N_BUL = 2,
    localparam int XW = $clog2(MAP_W),
    localparam int YW = $clog2(MAP_H)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               init_start,
    output logic               busy,
    output logic [XW-1:0]      lay_x,
    output logic [YW-1:0]      lay_y,
    input  logic [2:0]         lay_tile,
    input  logic [XW-1:0]      rd_x,
    input  logic [YW-1:0]      rd_y,
    output logic [2:0]         rd_tile,
    input  logic [N_BUL-1:0]   hit_valid,
    input  logic [N_BUL*XW-1:0] hit_x,
    input  logic [N_BUL*YW-1:0] hit_y,
    output logic [N_BUL-1:0]   hit_ready,
    output logic [N_BUL-1:0]   hit_done,
    output logic [N_BUL*3-1:0] hit_result,
    output logic [1:0]         base_hit,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam int NT = MAP_W * MAP_H;
    localparam int AW = $clog2(NT);
    localparam int RW = (N_BUL > 1) ? $clog2(N_BUL) : 1;
    localparam logic [XW:0]   W_LIM  = (XW+1)'(MAP_W);
    localparam logic [YW:0]   H_LIM  = (YW+1)'(MAP_H);
    localparam logic [XW-1:0] X_LAST = XW'(MAP_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(MAP_H - 1);
`ifdef TILE_MAP_WALL_HP_EN
    localparam logic [2:0] WALL_NEXT = 3'd5;
`else
    localparam logic [2:0] WALL_NEXT = 3'd0;
`endif

    logic [2:0]    mem_q [NT];
    state_t        state_q, state_d;
    logic [XW-1:0] sx_q, sx_d, hx_q, hx_d, gnt_x;
    logic [YW-1:0] sy_q, sy_d, hy_q, hy_d, gnt_y;
    logic [RW-1:0] rr_q, rr_d, ch_q, ch_d, gnt_ch;
    logic [2:0]    cur_q, cur_d, rd_q, new_tile;
    logic          pend_q, pend_d;
    logic [1:0]    base_q, base_d;
    logic [N_BUL-1:0] gnt;
    logic          we;
    logic [AW-1:0] waddr;
    logic [2:0]    wdata;

    function automatic logic [AW-1:0] tile_addr(logic [XW-1:0] x, logic [YW-1:0] y);
        return AW'(y) * AW'(MAP_W) + AW'(x);
    endfunction

    function automatic logic in_map(logic [XW-1:0] x, logic [YW-1:0] y);
        return ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
    endfunction

    // Round-robin pick: search starts one past the last served channel.
    always_comb begin
        int  c;
        logic found;
        c      = 0;
        found  = 1'b0;
        gnt    = '0;
        gnt_ch = '0;
        gnt_x  = '0;
        gnt_y  = '0;
        for (int k = 0; k < N_BUL; k++) begin
            c = (int'(rr_q) + 1 + k) % N_BUL;
            if (!found && hit_valid[c]) begin
                found     = 1'b1;
                gnt[c]    = 1'b1;
                gnt_ch    = RW'(c);
                gnt_x     = hit_x[c*XW +: XW];
                gnt_y     = hit_y[c*YW +: YW];
            end
        end
    end

    // Handshake: a request on channel i transfers in a cycle where hit_valid[i] and
    // hit_ready[i] are both high; ready is one-hot or zero and only offered in IDLE.
    assign hit_ready = (state_q == S_IDLE && !init_start) ? gnt : '0;

    always_comb begin
        new_tile = cur_q;
        case (cur_q)
            3'd2:       new_tile = WALL_NEXT;
            3'd3, 3'd4,
            3'd5:       new_tile = 3'd0;
            default:    new_tile = cur_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        hx_d       = hx_q;
        hy_d       = hy_q;
        rr_d       = rr_q;
        ch_d       = ch_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        base_d     = base_q;
        we         = 1'b0;
        waddr      = tile_addr(sx_q, sy_q);
        wdata      = lay_tile;
        hit_done   = '0;
        hit_result = '0;
        case (state_q)
            S_INIT: begin
                we = 1'b1;
                if (sx_q == X_LAST) begin
                    sx_d = '0;
                    if (sy_q == Y_LAST) begin
                        sy_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        sy_d = sy_q + 1'b1;
                    end
                end else begin
                    sx_d = sx_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (init_start) begin
                    state_d = S_INIT;
                    base_d  = '0;
                end else if (|hit_ready) begin
                    state_d = S_READ;
                    ch_d    = gnt_ch;
                    rr_d    = gnt_ch;
                    hx_d    = gnt_x;
                    hy_d    = gnt_y;
                end
            end
            S_READ: begin
                cur_d   = in_map(hx_q, hy_q) ? mem_q[tile_addr(hx_q, hy_q)] : 3'd1;
                state_d = S_WRITE;
                if (init_start) pend_d = 1'b1;
            end
            S_WRITE: begin
                hit_done[ch_q]          = 1'b1;
                hit_result[ch_q*3 +: 3] = cur_q;
                if (cur_q == 3'd3) base_d[0] = 1'b1;
                if (cur_q == 3'd4) base_d[1] = 1'b1;
                if (in_map(hx_q, hy_q) && new_tile != cur_q) begin
                    we    = 1'b1;
                    waddr = tile_addr(hx_q, hy_q);
                    wdata = new_tile;
                end
                if (pend_q || init_start) begin
                    state_d = S_INIT;
                    sx_d    = '0;
                    sy_d    = '0;
                    base_d  = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_INIT;
            sx_q    <= '0;
            sy_q    <= '0;
            hx_q    <= '0;
            hy_q    <= '0;
            rr_q    <= RW'(N_BUL - 1);
            ch_q    <= '0;
            cur_q   <= '0;
            pend_q  <= 1'b0;
            base_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            base_q  <= base_d;
            rd_q    <= in_map(rd_x, rd_y) ? mem_q[tile_addr(rd_x, rd_y)] : 3'd0;
        end
    end

    // Storage has no reset; its contents are rebuilt by the sweep.
    always_ff @(posedge Clk) begin
        if (we && Reset_n) mem_q[waddr] <= wdata;
    end

    assign busy      = (state_q == S_INIT);
    assign lay_x     = sx_q;
    assign lay_y     = sy_q;
    assign rd_tile   = busy ? 3'd0 : rd_q;
    assign base_hit  = base_q;
    assign dbg_state = state_q;

endmodule

// File: doc/tile_map_ctrl.md
TILE_MAP_CTRL -- requirements
Module: tile_map_ctrl

Interface
REQ-001 SHALL take parameter MAP_W, default 20: map width in tiles.
REQ-002 SHALL take parameter MAP_H, default 15: map height in tiles.
REQ-003 SHALL take parameter N_BUL, default 2: number of bullet-impact request channels.
REQ-004 SHALL use derived widths XW=$clog2(MAP_W) and YW=$clog2(MAP_H); tile codes are 3 bits: 0 empty, 1 border, 2 wall, 3 P1 base, 4 P2 base, 5 damaged wall.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL provide ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- init_start  in  1  pulse that requests reload of the default layout.
- busy  out  1  high while the init sweep is in progress.
- lay_x/lay_y  out  XW/YW  init-sweep address to the external layout ROM.
- lay_tile  in  3  ROM tile for lay_x/lay_y, valid in the same cycle.
- rd_x/rd_y  in  XW/YW  render read address.
- rd_tile  out  3  render read data.
- hit_valid  in  N_BUL  impact request per channel.
- hit_x/hit_y  in  N_BUL*XW/N_BUL*YW  impact coordinates, packed, channel 0 in the LSBs.
- hit_ready  out  N_BUL  acceptance of a request.
- hit_done  out  N_BUL  one-cycle completion pulse.
- hit_result  out  N_BUL*3  pre-update tile code at the impact, valid while hit_done is high.
- base_hit  out  2  sticky flags: bit0 P1 base destroyed, bit1 P2 base destroyed.

Function
REQ-007 SHALL store MAP_W*MAP_H 3-bit tiles, row-major.
REQ-008 SHALL implement the FSM states INIT, IDLE, READ, WRITE.
- Reset state is INIT.
- IDLE->INIT on init_start.
- IDLE->READ on a request accept.
- READ->WRITE unconditionally.
- WRITE->IDLE, or WRITE->INIT if an init_start is pending.
REQ-009 SHALL, in INIT, sweep one tile per cycle from (0,0) to (MAP_W-1,MAP_H-1), x fastest.
- Each cycle drives lay_x/lay_y and writes lay_tile.
- Total duration is exactly MAP_W*MAP_H cycles, then the FSM goes to IDLE.
- base_hit clears on INIT entry.
REQ-010 SHALL hold busy high in every INIT cycle and low otherwise; hit_ready is 0 in INIT.
REQ-011 SHALL ignore init_start while in INIT, and latch it while in READ or WRITE for action after WRITE.
REQ-012 SHALL register rd_tile with 1-cycle latency.
- rd_tile is 0 while busy.
- On a same-cycle write to the read address, rd_tile returns the old value.
REQ-013 SHALL accept at most one request per IDLE cycle.
- A transfer occurs when hit_valid[i] and hit_ready[i] are high in the same cycle.
- hit_ready is one-hot or zero, combinational on hit_valid, and asserted only in IDLE with init_start low.
REQ-014 SHALL grant round-robin: priority starts at (last served channel + 1) mod N_BUL; after reset, channel 0 has highest priority.
REQ-015 SHALL latch the coordinates at accept, read the tile in READ, and in WRITE write the update while pulsing hit_done[i] with hit_result[i].
- hit_done therefore occurs 2 cycles after accept.
- Minimum accept-to-accept spacing is 3 cycles.
REQ-016 SHALL apply these updates:
- 0 and 1: unchanged.
- 2: becomes 0, or 5 under REQ-020.
- 5: becomes 0.
- 3: becomes 0 and sets base_hit[0].
- 4: becomes 0 and sets base_hit[1].
REQ-017 SHALL treat x>=MAP_W or y>=MAP_H as result 1 with no write; the timing is the same as REQ-015.

Reset
REQ-018 SHALL, while Reset_n is low, immediately force:
- the FSM to INIT with the sweep counter at 0;
- busy=1, lay_x=lay_y=0, rd_tile=0;
- hit_ready=hit_done=0, hit_result=0, base_hit=0;
- the round-robin pointer to N_BUL-1 and the pending init cleared.
REQ-019 SHALL abort an in-flight request on reset with no hit_done pulse; tile contents are undefined until the sweep completes.

Configuration
REQ-020 SHALL, with TILE_MAP_WALL_HP_EN defined, make walls take two hits (2->5->0); without it, 2->0 in one hit and code 5 is never written by the block.

Verification
REQ-021 Release Reset_n with a ROM giving border 1 and interior 0 -> busy high exactly 300 cycles with lay addresses stepping (0,0)..(19,14); then rd (0,0) returns 1 and rd (5,5) returns 0.
REQ-022 Channel 0 hit at (6,4) holding 2 -> hit_ready[0] in the accept cycle, hit_done[0] with result 2 two cycles later, and rd (6,4) returns 0.
- With TILE_MAP_WALL_HP_EN, rd (6,4) returns 5 instead, and a second hit returns result 5 and leaves 0.
REQ-023 Both channels valid continuously from the first IDLE cycle -> accepts alternate ch0, ch1, ch0, ch1, spaced 3 cycles apart.
REQ-024 Hit at (9,13) holding 3 -> result 3, base_hit=01, tile 0; then init_start -> base_hit=00, busy for 300 cycles, and tile (9,13) restored to 3.
REQ-025 Hit at (25,3) -> result 1, no tile change, hit_done 2 cycles after accept.
REQ-026 Reset_n low in a WRITE cycle -> all outputs at reset values that cycle, no hit_done, and a fresh 300-cycle sweep after release.
